// File: rtl/spike_argmax_readout.sv
// Spike-count argmax readout: integrates per-class output spikes over WINDOW accepted
// timesteps, then scans the counts one class per cycle to report the winning class.
//
// state | meaning
// IDLE  | waiting for start; counters and result registers hold
// ACCUM | counting spikes on spike_valid cycles, WINDOW accepted steps
// SCAN  | one class compared per cycle, idx 0..N_CLASSES-1
// DONE  | publish scan result and pulse done on the way back to IDLE
module spike_argmax_readout #(
    parameter int N_CLASSES = 10,
    parameter int CNT_BITS  = 8,
    parameter int WINDOW    = 32
) (
    input  logic                 clk,
    input  logic                 rst_n,
    input  logic                 start,
    input  logic                 spike_valid,
    input  logic [N_CLASSES-1:0] spikes,
    output logic                 busy,
    output logic                 done,
    output logic [3:0]           class_out,
    output logic [CNT_BITS-1:0]  class_count,
    output logic                 tie,
    input  logic [3:0]           rd_sel,
    output logic [CNT_BITS-1:0]  rd_count
);

    typedef enum logic [1:0] {
        IDLE  = 2'd0,
        ACCUM = 2'd1,
        SCAN  = 2'd2,
        DONE  = 2'd3
    } state_t;

    localparam logic [CNT_BITS-1:0] CNT_MAX  = '1;
    localparam logic [CNT_BITS-1:0] CNT_ONE  = CNT_BITS'(1);
    localparam logic [15:0]         WIN_LOAD = 16'(WINDOW);
    localparam logic [3:0]          IDX_LAST = 4'(N_CLASSES - 1);

    state_t              state;
    logic [15:0]         steps_left;
    logic [3:0]          idx;
    logic [CNT_BITS-1:0] count [N_CLASSES];
    logic [CNT_BITS-1:0] best;
    logic [3:0]          best_idx;
    logic                tie_r;
    logic [CNT_BITS-1:0] scan_count;

    // Explicit mux loops keep out-of-range selects at zero instead of indexing past the array.
    always_comb begin
        scan_count = '0;
        rd_count   = '0;
        for (int i = 0; i < N_CLASSES; i++) begin
            if (idx == 4'(i)) begin
                scan_count = count[i];
            end
            if (rd_sel == 4'(i)) begin
                rd_count = count[i];
            end
        end
    end

    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            for (int i = 0; i < N_CLASSES; i++) begin
                count[i] <= '0;
            end
        end else if (state == IDLE && start) begin
            for (int i = 0; i < N_CLASSES; i++) begin
                count[i] <= '0;
            end
        end else if (state == ACCUM && spike_valid) begin
            for (int i = 0; i < N_CLASSES; i++) begin
                if (spikes[i] && count[i] != CNT_MAX) begin
                    count[i] <= count[i] + CNT_ONE;
                end
            end
        end
    end

    // steps_left counts down from WINDOW; the step that sees 1 is the last accepted one.
    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            state       <= IDLE;
            steps_left  <= '0;
            idx         <= '0;
            best        <= '0;
            best_idx    <= '0;
            tie_r       <= 1'b0;
            busy        <= 1'b0;
            done        <= 1'b0;
            class_out   <= '0;
            class_count <= '0;
            tie         <= 1'b0;
        end else begin
            done <= 1'b0;
            case (state)
                IDLE: begin
                    if (start) begin
                        state      <= ACCUM;
                        busy       <= 1'b1;
                        steps_left <= WIN_LOAD;
                    end
                end
                ACCUM: begin
                    if (spike_valid) begin
                        steps_left <= steps_left - 16'd1;
                        if (steps_left == 16'd1) begin
                            state <= SCAN;
                            idx   <= '0;
                        end
                    end
                end
                SCAN: begin
                    // Strict greater-than keeps the lowest index on equal counts.
                    if (idx == 4'd0 || scan_count > best) begin
                        best     <= scan_count;
                        best_idx <= idx;
                        tie_r    <= 1'b0;
                    end else if (scan_count == best) begin
                        tie_r <= 1'b1;
                    end
                    if (idx == IDX_LAST) begin
                        state <= DONE;
                        busy  <= 1'b0;
                    end else begin
                        idx <= idx + 4'd1;
                    end
                end
                DONE: begin
                    done        <= 1'b1;
                    class_out   <= best_idx;
                    class_count <= best;
                    tie         <= tie_r;
                    state       <= IDLE;
                end
                default: begin
                    state <= IDLE;
                    busy  <= 1'b0;
                end
            endcase
        end
    end

endmodule

// File: tb/tb_spike_argmax_readout.sv
// Bench for spike_argmax_readout: two instances (8-bit and 4-bit counters) share stimulus
// and are checked against a per-window tally / argmax reference model.
module tb_spike_argmax_readout;

    localparam int N  = 10;
    localparam int W  = 32;
    localparam int M8 = 255;
    localparam int M4 = 15;

    logic         clk;
    logic         rst_n;
    logic         start;
    logic         spike_valid;
    logic [N-1:0] spikes;
    logic [3:0]   rd_sel;

    logic         busy8, done8, tie8;
    logic [3:0]   class8;
    logic [7:0]   ccount8, rdc8;
    logic         busy4, done4, tie4;
    logic [3:0]   class4;
    logic [3:0]   ccount4, rdc4;

    int checks;
    int failures;

    logic [N-1:0] pat [W];
    int tally [N];
    int pc8, pn8, pt8, pc4, pn4, pt4;

    spike_argmax_readout #(.N_CLASSES(N), .CNT_BITS(8), .WINDOW(W)) dut8 (
        .clk(clk), .rst_n(rst_n), .start(start), .spike_valid(spike_valid), .spikes(spikes),
        .busy(busy8), .done(done8), .class_out(class8), .class_count(ccount8), .tie(tie8),
        .rd_sel(rd_sel), .rd_count(rdc8)
    );

    spike_argmax_readout #(.N_CLASSES(N), .CNT_BITS(4), .WINDOW(W)) dut4 (
        .clk(clk), .rst_n(rst_n), .start(start), .spike_valid(spike_valid), .spikes(spikes),
        .busy(busy4), .done(done4), .class_out(class4), .class_count(ccount4), .tie(tie4),
        .rd_sel(rd_sel), .rd_count(rdc4)
    );

    initial clk = 1'b0;
    always #5 clk = ~clk;

    task automatic check(input string tag, input logic [31:0] obs, input logic [31:0] exp);
        checks++;
        assert (obs === exp) else begin
            failures++;
            $error("FAIL %s observed=%0d expected=%0d", tag, obs, exp);
        end
    endtask

    function automatic int sat(input int v, input int maxv);
        return (v > maxv) ? maxv : v;
    endfunction

    // Reference: highest saturated tally, first class holding it, tie if more than one holds it.
    function automatic void argmax(input int maxv, output int win, output int wcnt, output int wtie);
        int m;
        int n;
        m   = -1;
        n   = 0;
        win = -1;
        for (int c = 0; c < N; c++) begin
            if (sat(tally[c], maxv) > m) m = sat(tally[c], maxv);
        end
        for (int c = 0; c < N; c++) begin
            if (sat(tally[c], maxv) == m) begin
                n++;
                if (win < 0) win = c;
            end
        end
        wcnt = m;
        wtie = (n > 1) ? 1 : 0;
    endfunction

    task automatic sweep_rd(input string name, input bit in_reset);
        for (int s = 0; s < 16; s++) begin
            rd_sel = 4'(s);
            #1;
            check({name, ":rd8"}, 32'(rdc8), (in_reset || s >= N) ? 0 : sat(tally[s], M8));
            check({name, ":rd4"}, 32'(rdc4), (in_reset || s >= N) ? 0 : sat(tally[s], M4));
        end
    endtask

    task automatic run_window(input string name, input int gap_pct, input bit noisy);
        int t, t_last, t_done8, t_done4, n_done8, n_done4, gaps;
        int w8, c8, e8, w4, c4, e4;
        for (int c = 0; c < N; c++) begin
            tally[c] = 0;
            for (int k = 0; k < W; k++) begin
                if (pat[k][c]) tally[c]++;
            end
        end
        argmax(M8, w8, c8, e8);
        argmax(M4, w4, c4, e4);

        @(negedge clk);
        start       = 1'b1;
        spike_valid = 1'b1;
        spikes      = N'($urandom);
        @(negedge clk);
        t = 0;
        check({name, ":busy8_start"}, 32'(busy8), 1);
        check({name, ":busy4_start"}, 32'(busy4), 1);
        check({name, ":hold_class"}, 32'(class8), 32'(pc8));
        check({name, ":hold_count"}, 32'(ccount8), 32'(pn8));
        check({name, ":hold_tie"}, 32'(tie8), 32'(pt8));
        check({name, ":hold_count4"}, 32'(ccount4), 32'(pn4));

        for (int k = 0; k < W; k++) begin
            gaps = 0;
            while (gap_pct > 0 && gaps < 8 && $urandom_range(99) < gap_pct) begin
                spike_valid = 1'b0;
                spikes      = N'($urandom);
                start       = noisy && ($urandom_range(1) == 1);
                @(negedge clk);
                t++;
                gaps++;
            end
            spike_valid = 1'b1;
            spikes      = pat[k];
            start       = noisy && ($urandom_range(1) == 1);
            @(negedge clk);
            t++;
        end
        t_last  = t;
        t_done8 = -1;
        t_done4 = -1;
        n_done8 = 0;
        n_done4 = 0;
        for (int j = 0; j <= N + 6; j++) begin
            if (done8) begin
                n_done8++;
                if (t_done8 < 0) t_done8 = t;
            end
            if (done4) begin
                n_done4++;
                if (t_done4 < 0) t_done4 = t;
            end
            spike_valid = ($urandom_range(1) == 1);
            spikes      = N'($urandom);
            start       = noisy && (j <= N) && ($urandom_range(1) == 1);
            @(negedge clk);
            t++;
        end
        start       = 1'b0;
        spike_valid = 1'b0;

        check({name, ":latency8"}, 32'(t_done8 - t_last), N + 1);
        check({name, ":latency4"}, 32'(t_done4 - t_last), N + 1);
        if (gap_pct == 0) check({name, ":lat_from_start"}, 32'(t_done8), W + N + 1);
        check({name, ":ndone8"}, 32'(n_done8), 1);
        check({name, ":ndone4"}, 32'(n_done4), 1);
        check({name, ":class8"}, 32'(class8), 32'(w8));
        check({name, ":count8"}, 32'(ccount8), 32'(c8));
        check({name, ":tie8"}, 32'(tie8), 32'(e8));
        check({name, ":class4"}, 32'(class4), 32'(w4));
        check({name, ":count4"}, 32'(ccount4), 32'(c4));
        check({name, ":tie4"}, 32'(tie4), 32'(e4));
        check({name, ":busy8_end"}, 32'(busy8), 0);
        sweep_rd(name, 1'b0);
        @(negedge clk);
        pc8 = w8; pn8 = c8; pt8 = e8;
        pc4 = w4; pn4 = c4; pt4 = e4;
    endtask

    initial begin
        int tgt [N];
        checks      = 0;
        failures    = 0;
        rst_n       = 1'b1;
        start       = 1'b0;
        spike_valid = 1'b0;
        spikes      = '0;
        rd_sel      = '0;
        pc8 = 0; pn8 = 0; pt8 = 0; pc4 = 0; pn4 = 0; pt4 = 0;

        // Reset state
        #1 rst_n = 1'b0;
        #2;
        check("rst:busy", 32'(busy8), 0);
        check("rst:done", 32'(done8), 0);
        check("rst:class", 32'(class8), 0);
        check("rst:count", 32'(ccount8), 0);
        check("rst:tie", 32'(tie8), 0);
        check("rst:busy4", 32'(busy4), 0);
        sweep_rd("rst", 1'b1);
        @(negedge clk);
        rst_n = 1'b1;

        // Class 3 every step, all others every 2nd step
        for (int k = 0; k < W; k++) begin
            pat[k]    = (k % 2 == 0) ? '1 : '0;
            pat[k][3] = 1'b1;
        end
        run_window("dom3", 0, 1'b0);

        // Classes 2 and 7 tie at 5, others 0..4
        for (int c = 0; c < N; c++) tgt[c] = (c == 2 || c == 7) ? 5 : int'($urandom_range(4));
        for (int k = 0; k < W; k++) begin
            for (int c = 0; c < N; c++) pat[k][c] = (((k + 3 * c) % W) < tgt[c]);
        end
        run_window("tie27", 0, 1'b0);

        // Saturation of the 4-bit counters
        for (int k = 0; k < W; k++) begin
            pat[k]    = '0;
            pat[k][0] = 1'b1;
            pat[k][1] = (k < 10);
        end
        run_window("sat", 0, 1'b0);

        // All-zero window
        for (int k = 0; k < W; k++) pat[k] = '0;
        run_window("zero", 0, 1'b0);

        // Random spikes, ~50% valid duty, start pulses during ACCUM/SCAN/DONE
        for (int r = 0; r < 2; r++) begin
            for (int k = 0; k < W; k++) pat[k] = N'($urandom);
            run_window("rand_gap", 50, 1'b1);
        end

        // Reset mid-ACCUM after 10 steps
        @(negedge clk);
        start = 1'b1;
        @(negedge clk);
        start = 1'b0;
        for (int k = 0; k < 10; k++) begin
            spike_valid = 1'b1;
            spikes      = '1;
            @(negedge clk);
        end
        spike_valid = 1'b0;
        check("midrst:busy_before", 32'(busy8), 1);
        #2 rst_n = 1'b0;
        #1;
        check("midrst:busy8", 32'(busy8), 0);
        check("midrst:busy4", 32'(busy4), 0);
        check("midrst:class", 32'(class8), 0);
        check("midrst:count", 32'(ccount8), 0);
        sweep_rd("midrst", 1'b1);
        @(negedge clk);
        rst_n = 1'b1;
        pc8 = 0; pn8 = 0; pt8 = 0; pc4 = 0; pn4 = 0; pt4 = 0;
        for (int k = 0; k < W; k++) pat[k] = N'($urandom);
        run_window("rerun", 0, 1'b0);

        $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
        $finish;
    end

endmodule
